// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 pixel-bus stream generator.
//   state_e      : frame sequencing states
//   PAT_*        : pattern_sel codes
//   BAR_*        : RGB565 colours of the eight colour bars, left to right
//   bar_colour() : bar index -> RGB565 colour
package ov7670_pkg;

  // state     | meaning
  // ----------+------------------------------------------------
  // ST_IDLE   | no frame in progress, waiting for enable
  // ST_VSYNC  | vsync high, VSYNC_LINES lines
  // ST_VBACK  | blank lines between vsync and first active line
  // ST_ACTIVE | V_ACTIVE lines, pixel bytes in the first 2*H_ACTIVE clks
  // ST_VFRONT | blank lines after the last active line
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBACK  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFRONT = 3'd4
  } state_e;

  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_GRAD  = 2'd1;
  localparam logic [1:0] PAT_FCNT  = 2'd2;
  localparam logic [1:0] PAT_FIXED = 2'd3;

  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ov7670_pattern_rgb565.sv
// Combinational RGB565 test-pattern generator.
//   pattern   : pattern code (PAT_*)
//   x, y      : pixel coordinates inside the active window
//   frame_cnt : running frame counter
//   fixed_rgb : colour used by the fixed-colour pattern
//   pixel     : resulting 16-bit RGB565 pixel
module ov7670_pattern_rgb565
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE = 640
) (
  input  logic [1:0]  pattern,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] frame_cnt,
  input  logic [15:0] fixed_rgb,
  output logic [15:0] pixel
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic [15:0] bar_idx;
  logic [2:0]  bar_sel;

  always_comb begin
    bar_idx = x / 16'(BAR_W);
    // x never leaves the active window, the clamp only keeps the index well defined
    bar_sel = (bar_idx > 16'd7) ? 3'd7 : bar_idx[2:0];
    case (pattern)
      PAT_BARS: pixel = bar_colour(bar_sel);
      PAT_GRAD: pixel = x + y;
      PAT_FCNT: pixel = frame_cnt;
      default:  pixel = fixed_rgb;
    endcase
  end

endmodule

// File: rtl/ov7670_stream_gen.sv
// OV7670 pixel-bus transmitter (VGA RGB565 timing) for sensor-less bring-up.
//   clk         : pixel-byte clock, two clocks per pixel
//   reset       : synchronous, active high
//   enable      : frames are generated while high; a started frame always completes
//   pattern_sel : pattern code, latched at frame start
//   fixed_rgb   : colour for the fixed pattern, latched at frame start
//   vsync       : high for the VSYNC lines
//   href        : high while d carries pixel bytes
//   d           : pixel byte, high byte first; zero while href is low
//   busy        : high while a frame is in progress
//   frame_done  : one-clock pulse on the final clock of a frame
module ov7670_stream_gen
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 144,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] fixed_rgb,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  d,
  output logic        busy,
  output logic        frame_done
);

  localparam int LINE_CLKS   = 2 * (H_ACTIVE + H_BLANK);
  localparam int FRAME_LINES = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;
  localparam int HW          = $clog2(LINE_CLKS);
  localparam int VW          = $clog2(FRAME_LINES);

  state_e        state_q, state_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [15:0]   fcnt_q, fcnt_d;
  logic [1:0]    pat_q, pat_d;
  logic [15:0]   fixed_q, fixed_d;

  logic          h_wrap;
  logic          line_last;

  logic          vsync_q, href_q, busy_q, frame_done_q;
  logic [7:0]    d_q;
  logic          vsync_d, href_d, busy_d, frame_done_d;
  logic [7:0]    d_d;

  logic [15:0]   pixel;
  logic [15:0]   x_w;
  logic [15:0]   y_w;

  // Outputs are registered from the next-state view so that they line up
  // with the state/counter registers in the same clock.
  assign x_w = 16'(h_d >> 1);
  assign y_w = 16'(v_d);

  ov7670_pattern_rgb565 #(
    .H_ACTIVE (H_ACTIVE)
  ) u_pattern (
    .pattern   (pat_q),
    .x         (x_w),
    .y         (y_w),
    .frame_cnt (fcnt_q),
    .fixed_rgb (fixed_q),
    .pixel     (pixel)
  );

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    fcnt_d  = fcnt_q;
    pat_d   = pat_q;
    fixed_d = fixed_q;

    h_wrap = (h_q == HW'(LINE_CLKS - 1));
    case (state_q)
      ST_VSYNC:  line_last = (v_q == VW'(VSYNC_LINES - 1));
      ST_VBACK:  line_last = (v_q == VW'(V_BACK - 1));
      ST_ACTIVE: line_last = (v_q == VW'(V_ACTIVE - 1));
      ST_VFRONT: line_last = (v_q == VW'(V_FRONT - 1));
      default:   line_last = 1'b0;
    endcase

    if (state_q == ST_IDLE) begin
      if (enable) begin
        state_d = ST_VSYNC;
        h_d     = '0;
        v_d     = '0;
        pat_d   = pattern_sel;
        fixed_d = fixed_rgb;
      end
    end else begin
      h_d = h_wrap ? '0 : h_q + HW'(1);
      if (h_wrap) begin
        if (line_last) begin
          v_d = '0;
          case (state_q)
            ST_VSYNC:  state_d = ST_VBACK;
            ST_VBACK:  state_d = ST_ACTIVE;
            ST_ACTIVE: state_d = ST_VFRONT;
            ST_VFRONT: begin
              fcnt_d = fcnt_q + 16'd1;
              // enable is only looked at here, so frames are never truncated
              if (enable) begin
                state_d = ST_VSYNC;
                pat_d   = pattern_sel;
                fixed_d = fixed_rgb;
              end else begin
                state_d = ST_IDLE;
              end
            end
            default:   state_d = ST_IDLE;
          endcase
        end else begin
          v_d = v_q + VW'(1);
        end
      end
    end

    vsync_d      = (state_d == ST_VSYNC);
    busy_d       = (state_d != ST_IDLE);
    href_d       = (state_d == ST_ACTIVE) && (h_d < HW'(2 * H_ACTIVE));
    frame_done_d = (state_d == ST_VFRONT) && (h_d == HW'(LINE_CLKS - 1))
                   && (v_d == VW'(V_FRONT - 1));
    if (href_d) d_d = h_d[0] ? pixel[7:0] : pixel[15:8];
    else        d_d = 8'h00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      h_q          <= '0;
      v_q          <= '0;
      fcnt_q       <= '0;
      pat_q        <= PAT_BARS;
      fixed_q      <= '0;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      d_q          <= 8'h00;
    end else begin
      state_q      <= state_d;
      h_q          <= h_d;
      v_q          <= v_d;
      fcnt_q       <= fcnt_d;
      pat_q        <= pat_d;
      fixed_q      <= fixed_d;
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      d_q          <= d_d;
    end
  end

  assign vsync      = vsync_q;
  assign href       = href_q;
  assign d          = d_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
